hazard_scoreboard_unit: RTL
===========================

// Module: hazard_scoreboard_unit
//
// PURPOSE
//   Hazard control for the 5-stage pipeline (F/D/E/M/W), extended for variable-latency multi-cycle ops (MUL/DIV unit, "MDU").
//   - Generates EX-stage operand forwarding selects.
//   - Generates load-use stalls and branch flushes.
//   - Keeps a per-register pending-write scoreboard for MDU results, so that dependent and WAW instructions stall in D until the result retires.
//   - Sits beside the pipeline registers and drives their stall/flush enables.
//
// PARAMETERS
//   REG_AW       5   register address width; the register file has 2**REG_AW entries
//   MAX_OUTST    2   max MDU ops in flight (1..2**REG_AW-1)
//   CNT_W        32  perf counter width (used only when HAZARD_PERF_CNT_EN is defined)
//
// PORTS
//   clk                 in   1       rising-edge clock
//   rst_n               in   1       asynchronous active-low reset
//   rs1_d, rs2_d        in   REG_AW  D-stage source registers
//   rd_d                in   REG_AW  D-stage destination register
//   mdu_op_d            in   1       D-stage instruction is an MDU op
//   reg_write_d         in   1       D-stage instruction writes rd
//   rs1_ex, rs2_ex      in   REG_AW  E-stage source registers
//   rd_ex               in   REG_AW  E-stage destination register
//   result_src_ex       in   1       E-stage instruction is a load
//   mdu_start_ex        in   1       MDU op issues from E this cycle
//   pc_src_ex           in   1       taken branch/jump resolved in E
//   rd_mem              in   REG_AW  M-stage destination register
//   reg_write_mem       in   1       M-stage write enable
//   rd_wb               in   REG_AW  W-stage destination register
//   reg_write_wb        in   1       W-stage write enable
//   mdu_done            in   1       MDU result written back this cycle
//   mdu_rd              in   REG_AW  destination register of the completing MDU op
//   forward_ae          out  2       00 regfile, 10 from M, 01 from W
//   forward_be          out  2       same encoding, for rs2
//   stall_fetch         out  1       hold PC
//   stall_decode        out  1       hold F/D register
//   flush_decode        out  1       clear F/D register
//   flush_execute       out  1       clear D/E register (insert bubble)
//   mdu_busy            out  1       outstanding count == MAX_OUTST
//   sb_error            out  1       sticky: mdu_done for a non-pending rd, or issue while full
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): pending[]=0, outstanding count=0, sb_error=0.
//     Outputs are combinational from inputs and state, so under reset with all inputs 0 every output is 0.
//   - Forwarding (combinational):
//     - forward_ae=10 if reg_write_mem && rd_mem==rs1_ex && rs1_ex!=0;
//     - else 01 if reg_write_wb && rd_wb==rs1_ex && rs1_ex!=0;
//     - else 00.
//     - forward_be: same rule using rs2_ex.
//     - M has priority over W.
//   - Stall causes (combinational; x0 never matches):
//     - lw_stall: result_src_ex && rd_ex!=0 && rd_ex in {rs1_d, rs2_d}.
//     - raw_stall: pending[rs1_d] or pending[rs2_d], or mdu_start_ex with rd_ex in {rs1_d, rs2_d}.
//     - waw_stall: reg_write_d && rd_d!=0 && (pending[rd_d] || (mdu_start_ex && rd_ex==rd_d)).
//     - struct_stall: mdu_op_d && (count + mdu_start_ex) >= MAX_OUTST.
//     - stall = lw_stall | raw_stall | waw_stall | struct_stall.
//   - Outputs:
//     - flush_decode = pc_src_ex.
//     - flush_execute = stall | pc_src_ex.
//     - stall_fetch = stall_decode = stall & ~pc_src_ex; a branch flush overrides a D stall.
//   - Scoreboard update (clock edge):
//     - mdu_start_ex && rd_ex!=0 sets pending[rd_ex].
//     - mdu_done clears pending[mdu_rd].
//     - Same register set and cleared in the same cycle: set wins.
//     - pending[0] is never set.
//   - Outstanding count:
//     - next = count + mdu_start_ex - mdu_done; simultaneous issue and done leaves it unchanged.
//     - Saturates at 0 and at MAX_OUTST.
//     - Underflow or overflow sets sb_error; the count does not change.
//   - sb_error also sets on mdu_done with pending[mdu_rd]==0 (mdu_rd!=0). It clears only on reset.
//   - Visibility: a pending bit set at edge t stalls D from cycle t+1 onward. During cycle t the rd_ex compare covers the hazard.
//   - Release: a pending bit cleared at edge t releases the stall in cycle t+1. The value reaches D through the regfile's write-first path.
//   - A reset asserted mid-operation drops all pending state. The MDU must be reset by the same rst_n.
//
// CONFIGURATION
//   - HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles[CNT_W] and flush_events[CNT_W].
//     - stall_cycles increments each cycle stall_decode=1.
//     - flush_events increments each cycle flush_decode=1.
//     - Both wrap at 2**CNT_W and reset to 0.
//   - Not defined: the ports and counters are absent and the behaviour is otherwise identical.
//
// TESTING
//   - rs1_ex=5, rd_mem=5, reg_write_mem=1, rd_wb=5, reg_write_wb=1 -> forward_ae=10.
//     Same with rs1_ex=0 -> forward_ae=00.
//   - result_src_ex=1, rd_ex=7, rs2_d=7 -> stall_fetch=stall_decode=flush_execute=1 for one cycle.
//     With rd_ex=0 -> all 0.
//   - mdu_start_ex with rd_ex=9; then rs1_d=9 on each following cycle -> stall held until the cycle after mdu_done with mdu_rd=9, then released.
//   - MAX_OUTST=2: two issues, then mdu_op_d=1 -> struct_stall and mdu_busy=1.
//     Simultaneous issue and done -> count stays 2.
//   - raw_stall active together with pc_src_ex=1 -> stall_fetch=0, flush_decode=1, flush_execute=1.
//   - mdu_done with mdu_rd=12, not pending -> sb_error=1 from the next cycle and held.
//     Assert rst_n=0 mid-op -> all pending bits and sb_error are 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_unit
// Description : Hazard control for a 5-stage F/D/E/M/W pipeline with a
//               variable-latency multiply/divide unit (MDU).
//               - EX-stage operand forwarding selects (M has priority over W)
//               - load-use, RAW, WAW and structural stalls of the D stage
//               - branch flushes of the F/D and D/E registers
//               - per-register pending-write scoreboard for MDU results
//                 and an outstanding-op counter with a sticky error flag
// Optional    : define HAZARD_PERF_CNT_EN to add the stall_cycles and
//               flush_events performance counters (CNT_W bits, wrapping).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_d         D-stage register addresses
//   mdu_op_d, reg_write_d      D-stage instruction is MDU op / writes rd
//   rs1_ex, rs2_ex, rd_ex      E-stage register addresses
//   result_src_ex              E-stage instruction is a load
//   mdu_start_ex               MDU op issues from E this cycle
//   pc_src_ex                  taken branch/jump resolved in E
//   rd_mem, reg_write_mem      M-stage destination / write enable
//   rd_wb, reg_write_wb        W-stage destination / write enable
//   mdu_done, mdu_rd           MDU writeback strobe and its destination
//   forward_ae, forward_be     00 regfile, 10 from M, 01 from W
//   stall_fetch, stall_decode  hold PC / hold F/D register
//   flush_decode               clear F/D register
//   flush_execute              clear D/E register (bubble)
//   mdu_busy                   outstanding MDU ops == MAX_OUTST
//   sb_error                   sticky scoreboard/count consistency error
//   stall_cycles, flush_events performance counters (optional)
// ============================================================================
module hazard_scoreboard_unit #(
    parameter int REG_AW    = 5,
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              mdu_op_d,
    input  logic              reg_write_d,
    input  logic [REG_AW-1:0] rs1_ex,
    input  logic [REG_AW-1:0] rs2_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              result_src_ex,
    input  logic              mdu_start_ex,
    input  logic              pc_src_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              reg_write_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              reg_write_wb,
    input  logic              mdu_done,
    input  logic [REG_AW-1:0] mdu_rd,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              stall_fetch,
    output logic              stall_decode,
    output logic              flush_decode,
    output logic              flush_execute,
    output logic              mdu_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events,
`endif
    output logic              sb_error
);

    localparam int            NREG  = 1 << REG_AW;
    localparam int            CW    = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
    localparam logic [CW:0]   MAX_W = (CW+1)'(MAX_OUTST);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   count_q,   count_d;
    logic            sb_error_q, sb_error_d;

    // ------------------------------------------------------------------
    // Forwarding: M stage is the younger producer, so it wins over W.
    // ------------------------------------------------------------------
    always_comb begin
        forward_ae = 2'b00;
        if (reg_write_mem && (rd_mem == rs1_ex) && (rs1_ex != '0))
            forward_ae = 2'b10;
        else if (reg_write_wb && (rd_wb == rs1_ex) && (rs1_ex != '0))
            forward_ae = 2'b01;
    end

    always_comb begin
        forward_be = 2'b00;
        if (reg_write_mem && (rd_mem == rs2_ex) && (rs2_ex != '0))
            forward_be = 2'b10;
        else if (reg_write_wb && (rd_wb == rs2_ex) && (rs2_ex != '0))
            forward_be = 2'b01;
    end

    // ------------------------------------------------------------------
    // Stall causes. pending_q[0] is never set, so x0 sources never match
    // the scoreboard; the rd_ex compares exclude x0 explicitly.
    // ------------------------------------------------------------------
    logic       ex_hits_src;
    logic       lw_stall;
    logic       raw_stall;
    logic       waw_stall;
    logic       struct_stall;
    logic       stall;
    logic [CW:0] count_plus_issue;

    assign ex_hits_src = (rd_ex != '0) && ((rd_ex == rs1_d) || (rd_ex == rs2_d));

    assign lw_stall  = result_src_ex && ex_hits_src;

    // An op issuing this cycle is not yet in the scoreboard; the rd_ex
    // compare covers it until the pending bit becomes visible next cycle.
    assign raw_stall = pending_q[rs1_d] || pending_q[rs2_d] ||
                       (mdu_start_ex && ex_hits_src);

    assign waw_stall = reg_write_d && (rd_d != '0) &&
                       (pending_q[rd_d] || (mdu_start_ex && (rd_ex == rd_d)));

    assign count_plus_issue = {1'b0, count_q} + (CW+1)'(mdu_start_ex);
    assign struct_stall     = mdu_op_d && (count_plus_issue >= MAX_W);

    assign stall = lw_stall | raw_stall | waw_stall | struct_stall;

    // A taken branch discards the D instruction, so its stall is moot.
    assign flush_decode  = pc_src_ex;
    assign flush_execute = stall | pc_src_ex;
    assign stall_fetch   = stall & ~pc_src_ex;
    assign stall_decode  = stall & ~pc_src_ex;

    assign mdu_busy = (count_q == MAX_C);
    assign sb_error = sb_error_q;

    // ------------------------------------------------------------------
    // Scoreboard next state: clear on completion first, then set on
    // issue, so a same-cycle set and clear of one register leaves it set.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (mdu_done)
            pending_d[mdu_rd] = 1'b0;
        if (mdu_start_ex && (rd_ex != '0))
            pending_d[rd_ex] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Outstanding count and error flag. Over/underflow attempts leave the
    // count untouched and raise the sticky error.
    // ------------------------------------------------------------------
    always_comb begin
        count_d    = count_q;
        sb_error_d = sb_error_q;
        if (mdu_start_ex && !mdu_done) begin
            if (count_q == MAX_C)
                sb_error_d = 1'b1;
            else
                count_d = count_q + CW'(1);
        end else if (mdu_done && !mdu_start_ex) begin
            if (count_q == '0)
                sb_error_d = 1'b1;
            else
                count_d = count_q - CW'(1);
        end
        if (mdu_done && (mdu_rd != '0) && !pending_q[mdu_rd])
            sb_error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            count_q    <= '0;
            sb_error_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_d;
            sb_error_q <= sb_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional performance counters (wrap naturally at 2**CNT_W).
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall_decode)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (flush_decode)
            flush_events_d = flush_events_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    // Keeps CNT_W referenced when the counters are not built.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
`default_nettype wire
